// File: rtl/aes_pkg.sv
// Shared AES decryption definitions.
// Holds the 128-bit block type, the sequencer FSM encoding, the NR-from-NK
// helper and the byte-level inverse transforms used by the round datapath.
// Byte 0 of a block sits at bits [0:7]; byte i maps to row i%4, column i/4.
package aes_pkg;

  typedef logic [0:127] state_t;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    FINAL,
    DONE
  } fsm_t;

  function automatic int nr_from_nk(input int nk);
    return nk + 6;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Inverse S-box computed rather than tabulated: undo the affine map, then
  // take the multiplicative inverse as t^254 = t^2 * t^4 * ... * t^128
  // (which conveniently maps 0 to 0).
  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    logic [7:0] t;
    logic [7:0] sq;
    logic [7:0] r;
    t  = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    sq = t;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    return r;
  endfunction

  // Row r is rotated right by r columns.
  function automatic state_t inv_shift_rows(input state_t s);
    state_t o;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[(c*4 + r)*8 +: 8] = s[(((c - r + 4) % 4)*4 + r)*8 +: 8];
      end
    end
    return o;
  endfunction

  function automatic state_t inv_sub_bytes(input state_t s);
    state_t o;
    for (int i = 0; i < 16; i++) begin
      o[i*8 +: 8] = inv_sbox(s[i*8 +: 8]);
    end
    return o;
  endfunction

  function automatic state_t inv_mix_columns(input state_t s);
    state_t o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[(c*4 + 0)*8 +: 8];
      a1 = s[(c*4 + 1)*8 +: 8];
      a2 = s[(c*4 + 2)*8 +: 8];
      a3 = s[(c*4 + 3)*8 +: 8];
      o[(c*4 + 0)*8 +: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[(c*4 + 1)*8 +: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[(c*4 + 2)*8 +: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[(c*4 + 3)*8 +: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction

endpackage

// File: rtl/inv_round.sv
// One combinational AES decryption round.
// Ports:
//   st_in  : current state block
//   rkey   : round key added after InvSubBytes
//   last   : final round, skip InvMixColumns
//   st_out : next state block
module inv_round
  import aes_pkg::*;
(
  input  state_t st_in,
  input  state_t rkey,
  input  logic   last,
  output state_t st_out
);

  state_t shifted;
  state_t subbed;
  state_t keyed;
  state_t mixed;

  always_comb begin
    shifted = inv_shift_rows(st_in);
    subbed  = inv_sub_bytes(shifted);
    keyed   = subbed ^ rkey;
    mixed   = inv_mix_columns(keyed);
    st_out  = last ? keyed : mixed;
  end

endmodule

// File: rtl/inv_cipher_seq.sv
// Iterative AES decryptor: one round datapath reused NR times.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : ciphertext handshake (ready only in IDLE)
//   in_block            : ciphertext, byte 0 at bits [0:7]
//   w                   : expanded key schedule, round key r at w[r*128 +: 128]
//   out_valid/out_ready : plaintext handshake
//   out_block           : plaintext, qualified by out_valid
//   busy                : any state other than IDLE
module inv_cipher_seq
  import aes_pkg::*;
#(
  parameter int NK = 4,
  parameter int NR = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [0:127]            in_block,
  input  logic [0:128*(NR+1)-1]   w,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [0:127]            out_block,
  output logic                    busy
);

  localparam int RND_W = $clog2(NR + 1);

  if (NR != nr_from_nk(NK)) begin : g_bad_nr
    $error("inv_cipher_seq: NR must equal NK+6");
  end

  fsm_t             state;
  fsm_t             state_nxt;
  state_t           st;
  logic [RND_W-1:0] rnd;
  logic [RND_W-1:0] key_idx;
  state_t           rk [0:NR];
  state_t           rkey;
  state_t           round_out;
  logic             last_round;

  for (genvar r = 0; r <= NR; r++) begin : g_rk
    assign rk[r] = w[r*128 +: 128];
  end

  // rnd stays at 1 through FINAL, so the last round forces key 0 explicitly.
  always_comb begin
    last_round = (state == FINAL);
    key_idx    = last_round ? '0 : rnd;
    rkey       = rk[key_idx];
  end

  inv_round u_round (
    .st_in  (st),
    .rkey   (rkey),
    .last   (last_round),
    .st_out (round_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid) state_nxt = ROUND;
      ROUND:   if (rnd == RND_W'(1)) state_nxt = FINAL;
      FINAL:   state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
    out_block = st;
  end

  // Initial AddRoundKey with the last round key happens on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st  <= '0;
      rnd <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            st  <= in_block ^ rk[NR];
            rnd <= RND_W'(NR - 1);
          end
        end
        ROUND: begin
          st <= round_out;
          if (rnd != RND_W'(1)) rnd <= rnd - RND_W'(1);
        end
        FINAL:   st <= round_out;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inv_cipher_seq.sv
// Directed bench for inv_cipher_seq: an NK=4 instance (FIPS-197 C.1 and
// appendix B vectors) and an NK=8 instance (FIPS-197 C.3). Key schedules are
// expanded here from the cipher keys with a forward S-box model.
module tb_inv_cipher_seq;

  localparam int NR_A = 10;
  localparam int NR_B = 14;

  localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_C3 = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic clk = 1'b0;
  logic rst_n;

  logic                     in_valid_a, in_ready_a, out_valid_a, out_ready_a, busy_a;
  logic [0:127]             in_block_a, out_block_a;
  logic [0:128*(NR_A+1)-1]  w_a;

  logic                     in_valid_b, in_ready_b, out_valid_b, out_ready_b, busy_b;
  logic [0:127]             in_block_b, out_block_b;
  logic [0:128*(NR_B+1)-1]  w_b;

  logic [0:128*(NR_A+1)-1]  w_c1;
  logic [0:128*(NR_A+1)-1]  w_appb;
  logic [0:1919]            full;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  inv_cipher_seq #(.NK(4), .NR(NR_A)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_a), .in_ready(in_ready_a), .in_block(in_block_a),
    .w(w_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .out_block(out_block_a),
    .busy(busy_a)
  );

  inv_cipher_seq #(.NK(8), .NR(NR_B)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .in_block(in_block_b),
    .w(w_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_block(out_block_b),
    .busy(busy_b)
  );

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Forward S-box: brute-force field inverse followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    for (int y = 1; y < 256; y++) begin
      if (gf_mul(x, 8'(y)) == 8'h01) inv = 8'(y);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  function automatic logic [0:1919] expand_key(input logic [0:255] key, input int nk);
    logic [31:0]   wd [60];
    logic [31:0]   t;
    logic [7:0]    rcon;
    logic [0:1919] o;
    int            total;
    total = 4 * (nk + 7);
    rcon  = 8'h01;
    o     = '0;
    for (int i = 0; i < total; i++) begin
      if (i < nk) begin
        wd[i] = key[i*32 +: 32];
      end else begin
        t = wd[i-1];
        if (i % nk == 0) begin
          t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
          rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
        end else if (nk > 6 && i % nk == 4) begin
          t = sub_word(t);
        end
        wd[i] = wd[i-nk] ^ t;
      end
      o[i*32 +: 32] = wd[i];
    end
    return o;
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one block to the NK=4 instance and wait (bounded) for out_valid.
  // lat counts edges after the accept edge until out_valid is seen.
  task automatic applyStimulus(input logic [127:0] ct, output int lat);
    checkOutput("in_ready before accept", 128'(in_ready_a), 128'(1));
    in_block_a = ct;
    in_valid_a = 1'b1;
    tick();
    in_valid_a = 1'b0;
    lat = 0;
    while (!out_valid_a && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    int   lat;
    int   acc_n, out_n, edge_n;
    int   acc_edge [2];
    logic acc, switch_pending;

    rst_n = 1'b0;
    in_valid_a = 1'b0; out_ready_a = 1'b0; in_block_a = '0;
    in_valid_b = 1'b0; out_ready_b = 1'b0; in_block_b = '0;
    full   = expand_key({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4);
    w_c1   = full[0:1407];
    full   = expand_key({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4);
    w_appb = full[0:1407];
    w_b    = expand_key(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8);
    w_a    = w_c1;

    tick();
    tick();
    checkOutput("reset in_ready", 128'(in_ready_a), 128'(1));
    checkOutput("reset out_valid", 128'(out_valid_a), 128'(0));
    checkOutput("reset busy", 128'(busy_a), 128'(0));
    checkOutput("reset out_block", out_block_a, 128'h0);
    checkOutput("reset in_ready nk8", 128'(in_ready_b), 128'(1));
    checkOutput("reset out_valid nk8", 128'(out_valid_b), 128'(0));
    rst_n = 1'b1;
    tick();

    // C.1 decryption with nominal latency
    applyStimulus(CT_C1, lat);
    checkOutput("c1 latency cycles", 128'(lat + 1), 128'(11));
    checkOutput("c1 plaintext", out_block_a, PT_C1);

    // Backpressure in DONE
    for (int k = 0; k < 5; k++) begin
      tick();
      checkOutput("hold out_valid", 128'(out_valid_a), 128'(1));
      checkOutput("hold out_block", out_block_a, PT_C1);
      checkOutput("hold in_ready", 128'(in_ready_a), 128'(0));
      checkOutput("hold busy", 128'(busy_a), 128'(1));
    end
    out_ready_a = 1'b1;
    tick();
    out_ready_a = 1'b0;
    checkOutput("release in_ready", 128'(in_ready_a), 128'(1));
    checkOutput("release out_valid", 128'(out_valid_a), 128'(0));
    checkOutput("release busy", 128'(busy_a), 128'(0));

    // Back-to-back with in_valid held high; key swapped after the first handshake
    out_ready_a = 1'b1;
    in_block_a  = CT_C1;
    in_valid_a  = 1'b1;
    acc_n = 0; out_n = 0; edge_n = 0; switch_pending = 1'b0;
    acc_edge[0] = 0; acc_edge[1] = 0;
    while (out_n < 2 && edge_n < 60) begin
      acc = in_ready_a && in_valid_a;
      tick();
      edge_n++;
      if (acc) begin
        if (acc_n < 2) acc_edge[acc_n] = edge_n;
        acc_n++;
      end
      if (switch_pending) begin
        in_block_a = CT_B;
        w_a = w_appb;
        switch_pending = 1'b0;
      end
      if (out_valid_a) begin
        if (out_n == 0) begin
          checkOutput("b2b plaintext 1", out_block_a, PT_C1);
          switch_pending = 1'b1;
        end else begin
          checkOutput("b2b plaintext 2", out_block_a, PT_B);
          in_valid_a = 1'b0;
        end
        out_n++;
      end
    end
    in_valid_a = 1'b0;
    tick();
    out_ready_a = 1'b0;
    checkOutput("b2b outputs", 128'(out_n), 128'(2));
    checkOutput("b2b accepts", 128'(acc_n), 128'(2));
    checkOutput("b2b accept spacing", 128'(acc_edge[1] - acc_edge[0]), 128'(12));
    checkOutput("b2b idle after", 128'(in_ready_a), 128'(1));
    w_a = w_c1;

    // Reset pulse five cycles after accept
    in_block_a = CT_C1;
    in_valid_a = 1'b1;
    tick();
    in_valid_a = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    rst_n = 1'b0;
    #1;
    checkOutput("midreset in_ready", 128'(in_ready_a), 128'(1));
    checkOutput("midreset out_valid", 128'(out_valid_a), 128'(0));
    checkOutput("midreset busy", 128'(busy_a), 128'(0));
    checkOutput("midreset out_block", out_block_a, 128'h0);
    tick();
    rst_n = 1'b1;
    tick();
    applyStimulus(CT_C1, lat);
    checkOutput("post-reset latency cycles", 128'(lat + 1), 128'(11));
    checkOutput("post-reset plaintext", out_block_a, PT_C1);
    out_ready_a = 1'b1;
    tick();
    out_ready_a = 1'b0;

    // NK=8 / NR=14 instance, FIPS-197 C.3
    checkOutput("nk8 in_ready before accept", 128'(in_ready_b), 128'(1));
    in_block_b = CT_C3;
    in_valid_b = 1'b1;
    tick();
    in_valid_b = 1'b0;
    lat = 0;
    while (!out_valid_b && lat < 40) begin
      tick();
      lat++;
    end
    checkOutput("nk8 latency cycles", 128'(lat + 1), 128'(15));
    checkOutput("nk8 plaintext", out_block_b, PT_C1);
    out_ready_b = 1'b1;
    tick();
    out_ready_b = 1'b0;
    checkOutput("nk8 back to idle", 128'(in_ready_b), 128'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
